// File: rtl/rgmii_tx_oddr_if.sv
// GMII byte side and RGMII pin side of the transmit adapter.
// The master modport is the MAC/bench side; the slave modport is the adapter.
interface rgmii_tx_oddr_if;
    logic       gmii_clk_en;
    logic [7:0] gmii_txd;
    logic       gmii_tx_en;
    logic       gmii_tx_er;
    logic       rgmii_txc;
    logic [3:0] rgmii_txd;
    logic       rgmii_tx_ctl;

    modport master (
        input  gmii_clk_en, rgmii_txc, rgmii_txd, rgmii_tx_ctl,
        output gmii_txd, gmii_tx_en, gmii_tx_er
    );

    modport slave (
        output gmii_clk_en, rgmii_txc, rgmii_txd, rgmii_tx_ctl,
        input  gmii_txd, gmii_tx_en, gmii_tx_er
    );
endinterface

// File: rtl/rgmii_tx_oddr.sv
// GMII-to-RGMII transmit adapter for 1G/100M/10M from a single 125 MHz clock.
// Define RGMII_TX_STATS_EN to add the frame_count/err_count outputs.
module rgmii_tx_oddr #(
    parameter string TARGET      = "GENERIC",
    parameter string IODDR_STYLE = "IODDR"
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           speed,
    rgmii_tx_oddr_if.slave       tx
`ifdef RGMII_TX_STATS_EN
   ,output logic [15:0]          frame_count,
    output logic [15:0]          err_count
`endif
);

    logic [1:0] spd_q, spd_d;
    logic [6:0] cnt_q, cnt_d;
    logic [9:0] hold_q, hold_d;    // {txd, en, er}
    logic       run_q;
    logic       gig, clk_en;
    logic [6:0] half_p, last, phase;
    logic [7:0] ph2;
    logic [3:0] nib;
    logic       en_h, er_h;
    logic [5:0] rise_d, fall_d;    // {txc, txd[3:0], ctl}
    logic [5:0] rise_q, fall_q, fall_r_q;

    always_comb begin
        gig    = spd_q[1];
        half_p = (spd_q == 2'b01) ? 7'd5 : 7'd50;
        last   = (spd_q == 2'b01) ? 7'd9 : 7'd99;
        clk_en = run_q & (gig | (cnt_q == last));

        cnt_d  = (clk_en || gig) ? 7'd0 : cnt_q + 7'd1;
        spd_d  = clk_en ? speed : spd_q;
        hold_d = clk_en ? {tx.gmii_txd, tx.gmii_tx_en, tx.gmii_tx_er} : hold_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spd_q  <= 2'b10;
            cnt_q  <= 7'd0;
            hold_q <= 10'd0;
            run_q  <= 1'b0;
        end else begin
            spd_q  <= spd_d;
            cnt_q  <= cnt_d;
            hold_q <= hold_d;
            run_q  <= 1'b1;
        end
    end

    assign tx.gmii_clk_en = clk_en;

    // Nibble phase k within the byte; txc is high for the first P half-cycles of each nibble.
    always_comb begin
        en_h  = hold_q[1];
        er_h  = hold_q[0];
        phase = (cnt_q < half_p) ? cnt_q : cnt_q - half_p;
        ph2   = {phase, 1'b0};
        nib   = (cnt_q < half_p) ? hold_q[5:2] : hold_q[9:6];
        if (gig) begin
            rise_d = {1'b1, hold_q[5:2], en_h};
            fall_d = {1'b0, hold_q[9:6], en_h ^ er_h};
        end else begin
            rise_d = {(ph2 < {1'b0, half_p}), nib, en_h};
            fall_d = {((ph2 | 8'd1) < {1'b0, half_p}), nib, en_h ^ er_h};
        end
    end

    // Same-edge capture: both halves are sampled on the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= 6'd0;
            fall_q <= 6'd0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    generate
        if (TARGET == "XILINX" && IODDR_STYLE == "IODDR2") begin : g_inv_clk
            // ODDR2 clocks its second half from an inverted copy of clk.
            logic clk_n;
            assign clk_n = ~clk;
            always_ff @(posedge clk_n or negedge rst_n) begin
                if (!rst_n) fall_r_q <= 6'd0;
                else        fall_r_q <= fall_q;
            end
        end else begin : g_neg_edge
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) fall_r_q <= 6'd0;
                else        fall_r_q <= fall_q;
            end
        end
    endgenerate

    logic [5:0] pins;
    assign pins            = clk ? rise_q : fall_r_q;
    assign tx.rgmii_txc    = pins[5];
    assign tx.rgmii_txd    = pins[4:1];
    assign tx.rgmii_tx_ctl = pins[0];

`ifdef RGMII_TX_STATS_EN
    logic [15:0] frame_q, frame_d, err_q, err_d;
    logic        prev_en_q, prev_en_d;

    always_comb begin
        frame_d   = frame_q;
        err_d     = err_q;
        prev_en_d = prev_en_q;
        if (clk_en) begin
            prev_en_d = tx.gmii_tx_en;
            if (tx.gmii_tx_en && !prev_en_q) frame_d = frame_q + 16'd1;
            if (tx.gmii_tx_en && tx.gmii_tx_er && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q   <= 16'd0;
            err_q     <= 16'd0;
            prev_en_q <= 1'b0;
        end else begin
            frame_q   <= frame_d;
            err_q     <= err_d;
            prev_en_q <= prev_en_d;
        end
    end

    assign frame_count = frame_q;
    assign err_count   = err_q;
`endif

endmodule

// File: tb/tb_rgmii_tx_oddr.sv
// Directed self-checking bench for rgmii_tx_oddr: reset, 1G mapping, 100M/10M pacing,
// mid-byte speed change and mid-byte reset.
module tb_rgmii_tx_oddr;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] speed = 2'b10;
    int         checks = 0;
    int         failures = 0;

    rgmii_tx_oddr_if tx_if ();

`ifdef RGMII_TX_STATS_EN
    logic [15:0] frame_count, err_count;
`endif

    rgmii_tx_oddr dut (
        .clk   (clk),
        .rst_n (rst_n),
        .speed (speed),
        .tx    (tx_if.slave)
`ifdef RGMII_TX_STATS_EN
       ,.frame_count (frame_count),
        .err_count   (err_count)
`endif
    );

    always #4 clk = ~clk;

    logic [7:0] gv_byte [4] = '{8'hA5, 8'h7E, 8'h00, 8'hC3};
    logic       gv_en   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic       gv_er   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [4:0] pat_r100 = 5'b00111;   // txc rising half vs nibble cycle, 100M
    logic [4:0] pat_f100 = 5'b00011;   // txc falling half vs nibble cycle, 100M

    task automatic set_byte(input logic [7:0] b, input logic en, input logic er);
        tx_if.gmii_txd   = b;
        tx_if.gmii_tx_en = en;
        tx_if.gmii_tx_er = er;
    endtask

    task automatic test_reset;
        set_byte(8'h00, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (tx_if.gmii_clk_en !== 1'b0) begin failures++; $display("FAIL rst_clk_en got %b exp 0", tx_if.gmii_clk_en); end
        checks++; if ({tx_if.rgmii_txc, tx_if.rgmii_txd, tx_if.rgmii_tx_ctl} !== 6'd0) begin
            failures++; $display("FAIL rst_pins_rise got %h exp 00", {tx_if.rgmii_txc, tx_if.rgmii_txd, tx_if.rgmii_tx_ctl}); end
        @(negedge clk); #1;
        checks++; if ({tx_if.rgmii_txc, tx_if.rgmii_txd, tx_if.rgmii_tx_ctl} !== 6'd0) begin
            failures++; $display("FAIL rst_pins_fall got %h exp 00", {tx_if.rgmii_txc, tx_if.rgmii_txd, tx_if.rgmii_tx_ctl}); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (tx_if.gmii_clk_en !== 1'b1) begin failures++; $display("FAIL rst_first_clk_en got %b exp 1", tx_if.gmii_clk_en); end
    endtask

`ifdef RGMII_TX_STATS_EN
    task automatic test_stats;
        checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL stats_frame_rst got %0d exp 0", frame_count); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL stats_err_rst got %0d exp 0", err_count); end
        set_byte(8'h11, 1'b1, 1'b0); @(posedge clk); #1;
        set_byte(8'h22, 1'b1, 1'b1); @(posedge clk); #1;
        set_byte(8'h00, 1'b0, 1'b0); @(posedge clk); #1;
        set_byte(8'h33, 1'b1, 1'b1); @(posedge clk); #1;
        set_byte(8'h00, 1'b0, 1'b0);
        checks++; if (frame_count !== 16'd2) begin failures++; $display("FAIL stats_frame got %0d exp 2", frame_count); end
        checks++; if (err_count !== 16'd2) begin failures++; $display("FAIL stats_err got %0d exp 2", err_count); end
    endtask
`endif

    task automatic test_gig;
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = gv_byte[i];
            @(posedge clk); #1; set_byte(b, gv_en[i], gv_er[i]);
            @(posedge clk); #1; set_byte(8'h00, 1'b0, 1'b0);
            @(posedge clk); #1;
            checks++; if (tx_if.gmii_clk_en !== 1'b1) begin failures++; $display("FAIL gig_clk_en[%0d] got %b exp 1", i, tx_if.gmii_clk_en); end
            checks++; if (tx_if.rgmii_txc !== 1'b1) begin failures++; $display("FAIL gig_txc_rise[%0d] got %b exp 1", i, tx_if.rgmii_txc); end
            checks++; if (tx_if.rgmii_txd !== b[3:0]) begin failures++; $display("FAIL gig_txd_rise[%0d] got %h exp %h", i, tx_if.rgmii_txd, b[3:0]); end
            checks++; if (tx_if.rgmii_tx_ctl !== gv_en[i]) begin failures++; $display("FAIL gig_ctl_rise[%0d] got %b exp %b", i, tx_if.rgmii_tx_ctl, gv_en[i]); end
            @(negedge clk); #1;
            checks++; if (tx_if.rgmii_txc !== 1'b0) begin failures++; $display("FAIL gig_txc_fall[%0d] got %b exp 0", i, tx_if.rgmii_txc); end
            checks++; if (tx_if.rgmii_txd !== b[7:4]) begin failures++; $display("FAIL gig_txd_fall[%0d] got %h exp %h", i, tx_if.rgmii_txd, b[7:4]); end
            checks++; if (tx_if.rgmii_tx_ctl !== (gv_en[i] ^ gv_er[i])) begin
                failures++; $display("FAIL gig_ctl_fall[%0d] got %b exp %b", i, tx_if.rgmii_tx_ctl, gv_en[i] ^ gv_er[i]); end
        end
    endtask

    task automatic test_100m;
        int c, k;
        logic [7:0] b;
        logic       e;
        logic [3:0] nib;
        @(posedge clk); #1; speed = 2'b01; set_byte(8'h3C, 1'b1, 1'b0);
        @(posedge clk); #1; set_byte(8'h00, 1'b0, 1'b0);
        checks++; if (tx_if.gmii_clk_en !== 1'b0) begin failures++; $display("FAIL m100_clk_en_start got %b exp 0", tx_if.gmii_clk_en); end
        for (int j = 1; j <= 20; j++) begin
            @(posedge clk); #1;
            c = (j - 1) % 10; k = c % 5;
            b = (j <= 10) ? 8'h3C : 8'h00; e = (j <= 10);
            nib = (c < 5) ? b[3:0] : b[7:4];
            checks++; if (tx_if.gmii_clk_en !== (j % 10 == 9)) begin failures++; $display("FAIL m100_clk_en[%0d] got %b", j, tx_if.gmii_clk_en); end
            checks++; if (tx_if.rgmii_txd !== nib) begin failures++; $display("FAIL m100_txd_rise[%0d] got %h exp %h", j, tx_if.rgmii_txd, nib); end
            checks++; if (tx_if.rgmii_txc !== pat_r100[k]) begin failures++; $display("FAIL m100_txc_rise[%0d] got %b exp %b", j, tx_if.rgmii_txc, pat_r100[k]); end
            checks++; if (tx_if.rgmii_tx_ctl !== e) begin failures++; $display("FAIL m100_ctl_rise[%0d] got %b exp %b", j, tx_if.rgmii_tx_ctl, e); end
            @(negedge clk); #1;
            checks++; if (tx_if.rgmii_txd !== nib) begin failures++; $display("FAIL m100_txd_fall[%0d] got %h exp %h", j, tx_if.rgmii_txd, nib); end
            checks++; if (tx_if.rgmii_txc !== pat_f100[k]) begin failures++; $display("FAIL m100_txc_fall[%0d] got %b exp %b", j, tx_if.rgmii_txc, pat_f100[k]); end
            checks++; if (tx_if.rgmii_tx_ctl !== e) begin failures++; $display("FAIL m100_ctl_fall[%0d] got %b exp %b", j, tx_if.rgmii_tx_ctl, e); end
        end
    endtask

    task automatic test_speed_change;
        int  k;
        bit  found = 0;
        logic [3:0] nib;
        for (int n = 0; n < 30 && !found; n++) begin
            @(posedge clk); #1;
            if (tx_if.gmii_clk_en === 1'b1) found = 1;
        end
        checks++; if (!found) begin failures++; $display("FAIL spd_sync_timeout got none exp clk_en within 30"); end
        set_byte(8'h96, 1'b1, 1'b0);
        @(posedge clk); #1; speed = 2'b10; set_byte(8'h00, 1'b0, 1'b0);
        for (int j = 1; j <= 10; j++) begin
            @(posedge clk); #1;
            k = (j - 1) % 5;
            nib = (j - 1 < 5) ? 4'h6 : 4'h9;
            checks++; if (tx_if.gmii_clk_en !== (j >= 9)) begin failures++; $display("FAIL spd_clk_en[%0d] got %b exp %b", j, tx_if.gmii_clk_en, j >= 9); end
            checks++; if (tx_if.rgmii_txd !== nib) begin failures++; $display("FAIL spd_txd[%0d] got %h exp %h", j, tx_if.rgmii_txd, nib); end
            checks++; if (tx_if.rgmii_txc !== pat_r100[k]) begin failures++; $display("FAIL spd_txc[%0d] got %b exp %b", j, tx_if.rgmii_txc, pat_r100[k]); end
        end
        @(posedge clk); #1;
        checks++; if (tx_if.rgmii_txc !== 1'b1) begin failures++; $display("FAIL spd_gig_txc_rise got %b exp 1", tx_if.rgmii_txc); end
        checks++; if (tx_if.rgmii_txd !== 4'h0) begin failures++; $display("FAIL spd_gig_txd got %h exp 0", tx_if.rgmii_txd); end
        checks++; if (tx_if.gmii_clk_en !== 1'b1) begin failures++; $display("FAIL spd_gig_clk_en got %b exp 1", tx_if.gmii_clk_en); end
        @(negedge clk); #1;
        checks++; if (tx_if.rgmii_txc !== 1'b0) begin failures++; $display("FAIL spd_gig_txc_fall got %b exp 0", tx_if.rgmii_txc); end
    endtask

    task automatic test_reset_mid_byte;
        @(posedge clk); #1; speed = 2'b01; set_byte(8'hFF, 1'b1, 1'b1);
        @(posedge clk); #1; set_byte(8'h00, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({tx_if.rgmii_txc, tx_if.rgmii_txd, tx_if.rgmii_tx_ctl} !== 6'd0) begin
            failures++; $display("FAIL rmid_pins_now got %h exp 00", {tx_if.rgmii_txc, tx_if.rgmii_txd, tx_if.rgmii_tx_ctl}); end
        checks++; if (tx_if.gmii_clk_en !== 1'b0) begin failures++; $display("FAIL rmid_clk_en got %b exp 0", tx_if.gmii_clk_en); end
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++; if ({tx_if.rgmii_txc, tx_if.rgmii_txd, tx_if.rgmii_tx_ctl} !== 6'd0) begin
            failures++; $display("FAIL rmid_pins_held got %h exp 00", {tx_if.rgmii_txc, tx_if.rgmii_txd, tx_if.rgmii_tx_ctl}); end
        rst_n = 1'b1; speed = 2'b10;
        @(posedge clk); #1;
        checks++; if (tx_if.gmii_clk_en !== 1'b1) begin failures++; $display("FAIL rmid_first_clk_en got %b exp 1", tx_if.gmii_clk_en); end
        checks++; if (tx_if.rgmii_txc !== 1'b1) begin failures++; $display("FAIL rmid_gig_txc_rise got %b exp 1", tx_if.rgmii_txc); end
        @(negedge clk); #1;
        checks++; if (tx_if.rgmii_txc !== 1'b0) begin failures++; $display("FAIL rmid_gig_txc_fall got %b exp 0", tx_if.rgmii_txc); end
        checks++; if (tx_if.rgmii_txd !== 4'h0) begin failures++; $display("FAIL rmid_txd got %h exp 0", tx_if.rgmii_txd); end
    endtask

    task automatic test_10m;
        int c, k;
        logic [3:0] nib;
        logic       txc_e;
        @(posedge clk); #1; speed = 2'b00; set_byte(8'h5A, 1'b1, 1'b0);
        @(posedge clk); #1; set_byte(8'h00, 1'b0, 1'b0);
        for (int j = 1; j <= 100; j++) begin
            @(posedge clk); #1;
            c = j - 1; k = c % 50;
            nib = (c < 50) ? 4'hA : 4'h5;
            txc_e = (k < 25);
            checks++; if (tx_if.gmii_clk_en !== (j == 99)) begin failures++; $display("FAIL m10_clk_en[%0d] got %b", j, tx_if.gmii_clk_en); end
            checks++; if (tx_if.rgmii_txd !== nib) begin failures++; $display("FAIL m10_txd[%0d] got %h exp %h", j, tx_if.rgmii_txd, nib); end
            checks++; if (tx_if.rgmii_txc !== txc_e) begin failures++; $display("FAIL m10_txc_rise[%0d] got %b exp %b", j, tx_if.rgmii_txc, txc_e); end
            @(negedge clk); #1;
            checks++; if (tx_if.rgmii_txc !== txc_e) begin failures++; $display("FAIL m10_txc_fall[%0d] got %b exp %b", j, tx_if.rgmii_txc, txc_e); end
            checks++; if (tx_if.rgmii_tx_ctl !== 1'b1) begin failures++; $display("FAIL m10_ctl_fall[%0d] got %b exp 1", j, tx_if.rgmii_tx_ctl); end
        end
    endtask

    initial begin
        test_reset;
`ifdef RGMII_TX_STATS_EN
        test_stats;
`endif
        test_gig;
        test_100m;
        test_speed_change;
        test_reset_mid_byte;
        test_10m;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
